tap_player: RTL and testbench

- Cassette playback stage sitting between the hps_io ioctl download path and the lynx48 core's tape input.
- Captures a TAP image into an internal byte buffer as it is downloaded.
- On request, serialises the buffer into a square-wave ear bitstream, gated by the core's tape-motor line.
- The top level ORs its ear output with the ADC tape ear before driving the core.

---
 rtl/tap_player_if.sv | 17 +
 rtl/tap_player.sv | 206 ++++++++++++++++++++
 tb/tb_tap_player.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/tap_player_if.sv
// tap_player_if: ioctl download bus from hps_io into the tape playback stage.
// The master drives the download strobes and data; tap_player is the slave.
interface tap_player_if;
   logic        ioctl_download;
   logic [7:0]  ioctl_index;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_data;

   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data
   );

   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_data
   );
endinterface

// File: rtl/tap_player.sv
// tap_player: captures a TAP image from the ioctl download path into a BRAM
// buffer and replays it as a square-wave ear bitstream gated by the tape motor.
// Optional macro TAP_TURBO_EN adds a turbo input that halves all half-periods.
module tap_player #(
   parameter int unsigned ADDR_W        = 16,
   parameter int unsigned TAP_INDEX     = 1,
   parameter int unsigned HALF0_CYC     = 1136,
   parameter int unsigned HALF1_CYC     = 2272,
   parameter int unsigned LEADER_HALVES = 1536
) (
   input  logic       clk_sys,
   input  logic       reset,
   tap_player_if.slave bus,
   input  logic       motor,
   input  logic       play,
`ifdef TAP_TURBO_EN
   input  logic       turbo,
`endif
   output logic       ear,
   output logic       active,
   output logic       overflow,
   output logic       loaded
);

   localparam int unsigned DEPTH = 2 ** ADDR_W;
   localparam int unsigned CNT_W = $clog2(HALF1_CYC + 1);
   localparam int unsigned HLV_W = $clog2(LEADER_HALVES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LEADER, S_FETCH, S_DATA
   } state_t;

   state_t            state_q;
   logic              sel_q, play_q;
   logic              ear_q, active_q, overflow_q, loaded_q;
   logic [ADDR_W:0]   length_q, length_d, len_base;
   logic [ADDR_W:0]   ptr_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [HLV_W-1:0]  halves_q;
   logic [7:0]        byte_q, rdata_q;
   logic [2:0]        bit_q;
   logic              second_q, fetch_ph_q, turbo_q;

   logic [7:0]        mem [0:DEPTH-1];

   logic              sel, sel_rise, sel_fall, play_rise;
   logic              in_range, wr_en, rd_en, turbo_s;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W:0]   addr_p1;
   logic [CNT_W-1:0]  lim0, lim1, lim_bit;
   logic              unused_idx;

`ifdef TAP_TURBO_EN
   assign turbo_s = turbo;
`else
   assign turbo_s = 1'b0;
`endif

   assign unused_idx = ^bus.ioctl_index[7:6];

   assign sel       = bus.ioctl_download && (bus.ioctl_index[5:0] == 6'(TAP_INDEX));
   assign sel_rise  = sel && !sel_q;
   assign sel_fall  = !sel && sel_q;
   assign play_rise = play && !play_q;
   assign in_range  = (bus.ioctl_addr >> ADDR_W) == '0;
   assign wr_en     = sel && bus.ioctl_wr && in_range;
   assign wr_addr   = bus.ioctl_addr[ADDR_W-1:0];
   assign addr_p1   = {1'b0, wr_addr} + (ADDR_W+1)'(1);
   assign rd_en     = (state_q == S_FETCH) && !fetch_ph_q;

   assign lim0    = turbo_q ? CNT_W'((HALF0_CYC >> 1) - 1) : CNT_W'(HALF0_CYC - 1);
   assign lim1    = turbo_q ? CNT_W'((HALF1_CYC >> 1) - 1) : CNT_W'(HALF1_CYC - 1);
   assign lim_bit = byte_q[bit_q] ? lim1 : lim0;

   // Image length tracks the highest written address + 1; a new download restarts it.
   always_comb begin
      len_base = sel_rise ? '0 : length_q;
      length_d = len_base;
      if (wr_en && (addr_p1 > len_base))
         length_d = addr_p1;
   end

   // Image buffer: download write port, registered playback read port.
   always_ff @(posedge clk_sys) begin
      if (wr_en)
         mem[wr_addr] <= bus.ioctl_data;
      if (rd_en)
         rdata_q <= mem[ptr_q[ADDR_W-1:0]];
   end

   // Load/playback state machine with registered outputs.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sel_q      <= 1'b0;
         play_q     <= 1'b0;
         ear_q      <= 1'b0;
         active_q   <= 1'b0;
         overflow_q <= 1'b0;
         loaded_q   <= 1'b0;
         length_q   <= '0;
         ptr_q      <= '0;
         cnt_q      <= '0;
         halves_q   <= '0;
         byte_q     <= '0;
         bit_q      <= '0;
         second_q   <= 1'b0;
         fetch_ph_q <= 1'b0;
         turbo_q    <= 1'b0;
      end else begin
         sel_q    <= sel;
         play_q   <= play;
         length_q <= length_d;
         if (sel_rise) begin
            state_q    <= S_LOAD;
            loaded_q   <= 1'b0;
            overflow_q <= bus.ioctl_wr && !in_range;
            ear_q      <= 1'b0;
            active_q   <= 1'b0;
         end else if (sel_fall) begin
            loaded_q <= (length_q != '0);
            state_q  <= S_IDLE;
         end else begin
            if (state_q == S_LOAD && bus.ioctl_wr && !in_range)
               overflow_q <= 1'b1;
            if (play_rise && loaded_q && state_q != S_LOAD) begin
               state_q  <= S_LEADER;
               active_q <= 1'b1;
               ear_q    <= 1'b0;
               ptr_q    <= '0;
               cnt_q    <= '0;
               halves_q <= '0;
               turbo_q  <= turbo_s;
            end else begin
               case (state_q)
                  S_LEADER: if (motor) begin
                     if (cnt_q == lim0) begin
                        cnt_q   <= '0;
                        ear_q   <= !ear_q;
                        turbo_q <= turbo_s;
                        if (halves_q == HLV_W'(LEADER_HALVES - 1)) begin
                           state_q    <= S_FETCH;
                           fetch_ph_q <= 1'b0;
                        end else begin
                           halves_q <= halves_q + HLV_W'(1);
                        end
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
                  // Two-cycle fetch holds ear: the level in force when a byte ends
                  // (high after a byte, low after the leader) stretches by 2 cycles.
                  S_FETCH: begin
                     if (!fetch_ph_q) begin
                        fetch_ph_q <= 1'b1;
                     end else begin
                        byte_q   <= rdata_q;
                        bit_q    <= 3'd7;
                        second_q <= 1'b0;
                        cnt_q    <= '0;
                        ear_q    <= 1'b1;
                        turbo_q  <= turbo_s;
                        state_q  <= S_DATA;
                     end
                  end
                  S_DATA: if (motor) begin
                     if (cnt_q == lim_bit) begin
                        cnt_q   <= '0;
                        turbo_q <= turbo_s;
                        if (!second_q) begin
                           ear_q    <= 1'b0;
                           second_q <= 1'b1;
                        end else begin
                           second_q <= 1'b0;
                           ear_q    <= 1'b1;
                           if (bit_q == 3'd0) begin
                              ptr_q <= ptr_q + (ADDR_W+1)'(1);
                              if (ptr_q + (ADDR_W+1)'(1) == length_q) begin
                                 state_q  <= S_IDLE;
                                 active_q <= 1'b0;
                                 ear_q    <= 1'b0;
                              end else begin
                                 state_q    <= S_FETCH;
                                 fetch_ph_q <= 1'b0;
                              end
                           end else begin
                              bit_q <= bit_q - 3'd1;
                           end
                        end
                     end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign ear      = ear_q;
   assign active   = active_q;
   assign overflow = overflow_q;
   assign loaded   = loaded_q;

endmodule

// File: tb/tb_tap_player.sv
// tb_tap_player: directed bench for tap_player with small timing parameters.
module tb_tap_player;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic motor = 1'b1;
   logic play = 1'b0;
   logic ear, active, overflow, loaded;

   int tests = 0;
   int fails = 0;

   tap_player_if bus();

   tap_player #(
      .ADDR_W(4), .TAP_INDEX(1), .HALF0_CYC(4), .HALF1_CYC(8), .LEADER_HALVES(4)
   ) dut (
      .clk_sys(clk), .reset(reset), .bus(bus.slave), .motor(motor), .play(play),
`ifdef TAP_TURBO_EN
      .turbo(1'b0),
`endif
      .ear(ear), .active(active), .overflow(overflow), .loaded(loaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        dl;
      logic [7:0]  idx;
      logic        wr;
      logic [24:0] addr;
      logic [7:0]  data;
      logic        exp_loaded;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[8];

   // Run lengths of ear levels (alternating, starting low) for image A5,00.
   int exp_runs[37] = '{4,4,4,4,2,
                        8,8,4,4,8,8,4,4,4,4,8,8,4,4,8,8,
                        6,4,4,4,4,4,4,4,4,4,4,4,4,4,4,4};

   int runs[0:511];
   int nruns, nsamp;
   logic [7:0] dec[0:31];
   int nbits;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic play_pulse();
      play = 1'b1;
      step();
      play = 1'b0;
   endtask

   // Record ear run lengths while active, bounded by a cycle budget.
   task automatic capture(input int budget);
      logic lvl;
      int len;
      nruns = 0; nsamp = 0; lvl = 1'b0; len = 0;
      while (active && nsamp < budget) begin
         if (ear == lvl) len++;
         else begin
            if (nruns < 512) runs[nruns] = len;
            nruns++;
            lvl = ear;
            len = 1;
         end
         nsamp++;
         step();
      end
      if (nruns < 512) runs[nruns] = len;
      nruns++;
      check("capture_timeout", int'(active), 0);
   endtask

   // Data high halves are the odd runs after the leader and gap; >=8 cycles is a 1.
   task automatic decode();
      nbits = 0;
      for (int i = 5; i < nruns && i < 512; i += 2) begin
         if (nbits < 256) dec[nbits/8] = {dec[nbits/8][6:0], runs[i] >= 8};
         nbits++;
      end
   endtask

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 37 + 5);
   endfunction

   initial begin
      vecs[0] = '{1'b1, 8'd1, 1'b0, 25'd0,  8'h00, 1'b0, 1'b0};
      vecs[1] = '{1'b1, 8'd1, 1'b1, 25'd0,  8'hA5, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 8'd1, 1'b1, 25'd1,  8'h00, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 8'd1, 1'b0, 25'd0,  8'h00, 1'b1, 1'b0};
      vecs[4] = '{1'b1, 8'd2, 1'b0, 25'd0,  8'h00, 1'b1, 1'b0};
      vecs[5] = '{1'b1, 8'd2, 1'b1, 25'd0,  8'hFF, 1'b1, 1'b0};
      vecs[6] = '{1'b1, 8'd2, 1'b1, 25'd20, 8'h11, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 8'd2, 1'b0, 25'd0,  8'h00, 1'b1, 1'b0};

      bus.ioctl_download = 1'b0; bus.ioctl_index = 8'd0; bus.ioctl_wr = 1'b0;
      bus.ioctl_addr = '0; bus.ioctl_data = '0;

      step(); step();
      check("rst_ear", int'(ear), 0);
      check("rst_active", int'(active), 0);
      check("rst_overflow", int'(overflow), 0);
      check("rst_loaded", int'(loaded), 0);
      reset = 1'b0;
      step();

      // Download A5,00 via slot 1, then a foreign slot 2 download.
      for (int i = 0; i < 8; i++) begin
         bus.ioctl_download = vecs[i].dl;
         bus.ioctl_index    = vecs[i].idx;
         bus.ioctl_wr       = vecs[i].wr;
         bus.ioctl_addr     = vecs[i].addr;
         bus.ioctl_data     = vecs[i].data;
         step();
         check($sformatf("vec%0d_loaded", i), int'(loaded), int'(vecs[i].exp_loaded));
         check($sformatf("vec%0d_overflow", i), int'(overflow), int'(vecs[i].exp_ovf));
         check($sformatf("vec%0d_active", i), int'(active), 0);
      end
      bus.ioctl_wr = 1'b0;

      // Full playback waveform.
      play_pulse();
      check("play_active", int'(active), 1);
      check("play_ear0", int'(ear), 0);
      capture(1000);
      check("play_samples", nsamp, 180);
      check("play_nruns", nruns, 37);
      for (int i = 0; i < 37; i++)
         if (i < nruns) check($sformatf("run%0d", i), runs[i], exp_runs[i]);
      check("end_ear", int'(ear), 0);

      // Motor stop during the third leader half-period.
      play_pulse();
      fork
         capture(1000);
         begin
            repeat (9) step();
            motor = 1'b0;
            repeat (50) step();
            motor = 1'b1;
         end
      join
      check("motor_samples", nsamp, 230);
      check("motor_nruns", nruns, 37);
      check("motor_run1", runs[1], 4);
      check("motor_run2", runs[2], 54);
      check("motor_run3", runs[3], 4);

      // Oversized image: 20 bytes into a 16-byte buffer.
      bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd1;
      step();
      check("ovf_clear_loaded", int'(loaded), 0);
      for (int i = 0; i < 20; i++) begin
         bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'(i); bus.ioctl_data = pat(i);
         step();
         if (i == 15) check("ovf_at15", int'(overflow), 0);
         if (i == 16) check("ovf_at16", int'(overflow), 1);
      end
      bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
      step();
      check("ovf_sticky", int'(overflow), 1);
      check("ovf_loaded", int'(loaded), 1);
      play_pulse();
      capture(4000);
      decode();
      check("ovf_bits", nbits, 128);
      for (int j = 0; j < 16; j++)
         check($sformatf("ovf_byte%0d", j), int'(dec[j]), int'(pat(j)));

      // Download start mid-DATA wins over a simultaneous play edge.
      play_pulse();
      repeat (28) step();
      check("abort_pre_active", int'(active), 1);
      bus.ioctl_download = 1'b1; bus.ioctl_index = 8'd1; play = 1'b1;
      step();
      check("abort_active", int'(active), 0);
      check("abort_ear", int'(ear), 0);
      check("abort_loaded", int'(loaded), 0);
      play = 1'b0;
      step();
      play_pulse();
      step();
      check("abort_play_ignored", int'(active), 0);
      bus.ioctl_wr = 1'b1; bus.ioctl_addr = 25'd0; bus.ioctl_data = 8'h5A;
      step();
      bus.ioctl_wr = 1'b0; bus.ioctl_download = 1'b0;
      step();
      check("reload_loaded", int'(loaded), 1);
      check("reload_overflow", int'(overflow), 0);
      play_pulse();
      capture(1000);
      decode();
      check("reload_samples", nsamp, 114);
      check("reload_bits", nbits, 8);
      check("reload_byte", int'(dec[0]), 8'h5A);

      // Asynchronous reset mid-DATA.
      play_pulse();
      repeat (25) step();
      check("ar_pre_active", int'(active), 1);
      #2 reset = 1'b1;
      #1;
      check("ar_ear", int'(ear), 0);
      check("ar_active", int'(active), 0);
      check("ar_loaded", int'(loaded), 0);
      check("ar_overflow", int'(overflow), 0);
      #2 reset = 1'b0;
      step();
      play_pulse();
      begin
         int seen = 0;
         for (int i = 0; i < 20; i++) begin
            if (active || ear) seen = 1;
            step();
         end
         check("ar_play_ignored", seen, 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
